// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution window feeder: FSM encoding and
// default pixel width / image dimensions.
package conv_pkg;

   localparam int unsigned N_DEF     = 8;
   localparam int unsigned IMG_W_DEF = 28;
   localparam int unsigned IMG_H_DEF = 28;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: dout is din delayed by DEPTH shift_en events.
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter int unsigned N     = N_DEF,
   parameter int unsigned DEPTH = IMG_W_DEF
) (
   input  logic         Clk,
   input  logic         Rst_n,
   input  logic         shift_en,
   input  logic [N-1:0] din,
   output logic [N-1:0] dout
);

   logic [N-1:0] sr_q [DEPTH];

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else if (shift_en) begin
         sr_q[0] <= din;
         for (int unsigned i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
   end

   assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/conv_window_feeder.sv
// Raster pixel stream to 3x3 sliding window for the convolution systolic array.
// Two line buffers supply rows r-2 and r-1; the window register shifts on accept.
module conv_window_feeder
   import conv_pkg::*;
#(
   parameter int unsigned N     = N_DEF,
   parameter int unsigned IMG_W = IMG_W_DEF,
   parameter int unsigned IMG_H = IMG_H_DEF
) (
   input  logic         Clk,
   input  logic         Rst_n,
   input  logic         start,
   input  logic [N-1:0] pix_in,
   input  logic         pix_valid,
   output logic         pix_ready,
   output logic [N-1:0] F1,
   output logic [N-1:0] F2,
   output logic [N-1:0] F3,
   output logic [N-1:0] F4,
   output logic [N-1:0] F5,
   output logic [N-1:0] F6,
   output logic [N-1:0] F7,
   output logic [N-1:0] F8,
   output logic [N-1:0] F9,
   output logic         win_valid,
   output logic         frame_done
);

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [N-1:0]  win_q [9];
   logic [N-1:0]  win_d [9];
   logic          wv_q, wv_d;

   logic          accept;
   logic          col_wrap;
   logic [N-1:0]  lb0_out, lb1_out;

   assign pix_ready = (state_q == ST_FILL) || (state_q == ST_RUN);
   assign accept    = pix_valid && pix_ready;
   assign col_wrap  = (col_q == COL_LAST);

   conv_line_buffer #(.N(N), .DEPTH(IMG_W)) u_lb0 (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .shift_en (accept),
      .din      (pix_in),
      .dout     (lb0_out)
   );

   conv_line_buffer #(.N(N), .DEPTH(IMG_W)) u_lb1 (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .shift_en (accept),
      .din      (lb0_out),
      .dout     (lb1_out)
   );

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FILL;
               col_d   = '0;
               row_d   = '0;
            end
         end
         ST_FILL: begin
            if (accept) begin
               if (col_wrap) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
                  if (row_q == RW'(1)) state_d = ST_RUN;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (accept) begin
               if (col_wrap) begin
                  col_d = '0;
                  if (row_q == ROW_LAST) state_d = ST_DONE;
                  else                   row_d   = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Window shifts on every accept, even for c<2, so it is primed at c=2.
   always_comb begin
      for (int unsigned i = 0; i < 9; i++) win_d[i] = win_q[i];
      if (accept) begin
         win_d[0] = win_q[1];
         win_d[1] = win_q[2];
         win_d[2] = lb1_out;
         win_d[3] = win_q[4];
         win_d[4] = win_q[5];
         win_d[5] = lb0_out;
         win_d[6] = win_q[7];
         win_d[7] = win_q[8];
         win_d[8] = pix_in;
      end
      wv_d = accept && (state_q == ST_RUN) && (col_q >= CW'(2));
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= ST_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         wv_q    <= 1'b0;
         for (int unsigned i = 0; i < 9; i++) win_q[i] <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         wv_q    <= wv_d;
         for (int unsigned i = 0; i < 9; i++) win_q[i] <= win_d[i];
      end
   end

   assign win_valid  = wv_q;
   assign frame_done = (state_q == ST_DONE);

   assign F1 = win_q[0];
   assign F2 = win_q[1];
   assign F3 = win_q[2];
   assign F4 = win_q[3];
   assign F5 = win_q[4];
   assign F6 = win_q[5];
   assign F7 = win_q[6];
   assign F8 = win_q[7];
   assign F9 = win_q[8];

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder on a 5x4 frame with p(r,c)=5r+c.
module tb_conv_window_feeder;

   localparam int W     = 5;
   localparam int H     = 4;
   localparam int TOTAL = W * H;
   localparam int NWIN  = (W - 2) * (H - 2);

   logic       Clk = 1'b0;
   logic       Rst_n;
   logic       start;
   logic [7:0] pix_in;
   logic       pix_valid;
   logic       pix_ready;
   logic [7:0] F1, F2, F3, F4, F5, F6, F7, F8, F9;
   logic       win_valid;
   logic       frame_done;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int              r;
      int              c;
      logic [0:8][7:0] f;
   } win_vec_t;

   win_vec_t tbl [NWIN];

   conv_window_feeder #(.N(8), .IMG_W(W), .IMG_H(H)) dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .start      (start),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .F1         (F1),
      .F2         (F2),
      .F3         (F3),
      .F4         (F4),
      .F5         (F5),
      .F6         (F6),
      .F7         (F7),
      .F8         (F8),
      .F9         (F9),
      .win_valid  (win_valid),
      .frame_done (frame_done)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", nm, act, act, exp, exp);
      end
   endtask

   function automatic logic [7:0] pix(input int r, input int c, input int mode);
      if (mode == 1 && r == 2 && c == 2) return 8'h80;
      if (mode == 1 && r == 3 && c == 4) return 8'h7F;
      return 8'(5 * r + c);
   endfunction

   // Mode 1 replaces the values 12 and 19 (unique in the 5r+c frame).
   function automatic logic [7:0] patch(input logic [7:0] v, input int mode);
      if (mode == 1 && v == 8'd12) return 8'h80;
      if (mode == 1 && v == 8'd19) return 8'h7F;
      return v;
   endfunction

   task automatic chk_window(input int w, input int mode);
      logic [0:8][7:0] act;
      act = {F1, F2, F3, F4, F5, F6, F7, F8, F9};
      for (int k = 0; k < 9; k++)
         chk($sformatf("win%0d_F%0d", w, k + 1), act[k], patch(tbl[w].f[k], mode));
   endtask

   task automatic run_frame(input int mode, input bit toggle, input int abort_after,
                            input int start_at);
      int   idx = 0;
      int   w   = 0;
      int   cyc = 0;
      int   nwin = 0;
      int   nfd  = 0;
      int   rowwin [H];
      bit   acc;
      bit   exp_wv;
      int   r, c;
      for (int i = 0; i < H; i++) rowwin[i] = 0;

      @(negedge Clk);
      start = 1'b1;
      @(posedge Clk);
      #1;
      start = 1'b0;

      while (idx < TOTAL && cyc < 400) begin
         @(negedge Clk);
         r = idx / W;
         c = idx % W;
         pix_in    = pix(r, c, mode);
         pix_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
         start     = (start_at >= 0 && idx == start_at);
         chk($sformatf("pix_ready_busy_%0d", idx), pix_ready, 1);
         acc = pix_valid;
         @(posedge Clk);
         #1;
         start = 1'b0;
         exp_wv = acc && (w < NWIN) && tbl[w].r == r && tbl[w].c == c;
         chk($sformatf("win_valid_cyc%0d", cyc), win_valid, exp_wv);
         if (win_valid) begin
            nwin++;
            if (acc) rowwin[r]++;
            else     rowwin[0]++;
         end
         if (exp_wv) begin
            chk_window(w, mode);
            w++;
         end
         chk($sformatf("frame_done_cyc%0d", cyc), frame_done, acc && idx == TOTAL - 1);
         if (frame_done) nfd++;
         if (acc) idx++;
         cyc++;
         if (abort_after > 0 && idx == abort_after) return;
      end
      if (cyc >= 400) chk("frame_timeout", 0, 1);

      if (mode == 1) begin
         chk("last_F9_127", F9, 8'h7F);
      end

      pix_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         pix_valid = 1'b1;
         @(posedge Clk);
         #1;
         chk($sformatf("post_win_valid_%0d", i), win_valid, 0);
         chk($sformatf("post_frame_done_%0d", i), frame_done, 0);
         chk($sformatf("post_pix_ready_%0d", i), pix_ready, 0);
         if (win_valid) nwin++;
         if (frame_done) nfd++;
      end
      pix_valid = 1'b0;

      chk("window_count", nwin, NWIN);
      chk("frame_done_count", nfd, 1);
      chk("row0_1_windows", rowwin[0] + rowwin[1], 0);
      chk("row2_windows", rowwin[2], 3);
      chk("row3_windows", rowwin[3], 3);
   endtask

   initial begin
      tbl[0] = '{r: 2, c: 2, f: {8'd0, 8'd1, 8'd2,  8'd5,  8'd6,  8'd7,  8'd10, 8'd11, 8'd12}};
      tbl[1] = '{r: 2, c: 3, f: {8'd1, 8'd2, 8'd3,  8'd6,  8'd7,  8'd8,  8'd11, 8'd12, 8'd13}};
      tbl[2] = '{r: 2, c: 4, f: {8'd2, 8'd3, 8'd4,  8'd7,  8'd8,  8'd9,  8'd12, 8'd13, 8'd14}};
      tbl[3] = '{r: 3, c: 2, f: {8'd5, 8'd6, 8'd7,  8'd10, 8'd11, 8'd12, 8'd15, 8'd16, 8'd17}};
      tbl[4] = '{r: 3, c: 3, f: {8'd6, 8'd7, 8'd8,  8'd11, 8'd12, 8'd13, 8'd16, 8'd17, 8'd18}};
      tbl[5] = '{r: 3, c: 4, f: {8'd7, 8'd8, 8'd9,  8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19}};

      Rst_n     = 1'b0;
      start     = 1'b0;
      pix_in    = '0;
      pix_valid = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      chk("reset_pix_ready", pix_ready, 0);
      chk("reset_win_valid", win_valid, 0);
      chk("reset_frame_done", frame_done, 0);
      chk("reset_F", {F1, F2, F3, F4}, 0);
      @(negedge Clk);
      Rst_n = 1'b1;

      // Case 1 and row-boundary check: valid held high.
      run_frame(0, 1'b0, 0, -1);
      // Case 2: pix_valid toggled 1,0,1,0.
      run_frame(0, 1'b1, 0, -1);
      // Case 3: extreme values at (2,2) and (3,4).
      run_frame(1, 1'b0, 0, -1);

      // Case 4: reset after 9 accepts, then a clean frame.
      run_frame(0, 1'b0, 9, -1);
      @(negedge Clk);
      Rst_n     = 1'b0;
      pix_valid = 1'b0;
      @(posedge Clk);
      #1;
      chk("abort_F1_4", {F1, F2, F3, F4}, 0);
      chk("abort_F5_8", {F5, F6, F7, F8}, 0);
      chk("abort_F9", F9, 0);
      chk("abort_win_valid", win_valid, 0);
      chk("abort_frame_done", frame_done, 0);
      chk("abort_pix_ready", pix_ready, 0);
      @(negedge Clk);
      Rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         pix_valid = 1'b1;
         @(posedge Clk);
         #1;
         chk($sformatf("abort_idle_wv_%0d", i), win_valid, 0);
         chk($sformatf("abort_idle_fd_%0d", i), frame_done, 0);
         chk($sformatf("abort_idle_ready_%0d", i), pix_ready, 0);
      end
      pix_valid = 1'b0;
      run_frame(0, 1'b0, 0, -1);

      // Case 5: start pulsed during RUN (pixel 12 = row 2, col 2).
      run_frame(0, 1'b0, 0, 12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
